rr_display_arbiter: RTL and testbench

//  Round-robin arbiter that shares one grant slot, and the 7-segment display, among 8 requesters.

---
 rtl/rr_display_arbiter.sv | 125 ++++++++++++
 tb/tb_rr_display_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_display_arbiter.sv
// Round-robin arbiter for 8 requesters sharing one grant slot and a 7-segment display.
// Grants are registered, held until done, request drop or MAX_HOLD timeout, followed by a GAP.
module rr_display_arbiter #(
  parameter int unsigned MAX_HOLD   = 15,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic       grant_valid,
  output logic       timeout,
  output logic [6:0] segments,
  output logic       none
);

  localparam int unsigned    CW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  CNT_MAX  = (MAX_HOLD == 0) ? '1 : CW'(MAX_HOLD);
  localparam logic [3:0]     GAP_INIT = 4'(GAP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [2:0]    ptr_q;
  logic [2:0]    gidx_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    gap_q;
  logic [7:0]    grant_q;
  logic          timeout_q;
  logic [6:0]    seg_q;

  logic [2:0]    win;
  logic [2:0]    idx;
  logic          found;
  logic          hold_hit;
  logic          rel;

  function automatic logic [6:0] digit(input logic [2:0] k);
    logic [6:0] d;
    unique case (k)
      3'd0: d = 7'b0111111;
      3'd1: d = 7'b0000110;
      3'd2: d = 7'b1011011;
      3'd3: d = 7'b1001111;
      3'd4: d = 7'b1100110;
      3'd5: d = 7'b1101101;
      3'd6: d = 7'b1111101;
      default: d = 7'b0000111;
    endcase
    return d;
  endfunction

  // Descending search from ptr with wrap: the first set request wins.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = ptr_q - 3'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign hold_hit = (MAX_HOLD != 0) && (cnt_q == CNT_MAX);
  assign rel      = done || !req[gidx_q] || hold_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'd7;
      gidx_q    <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      grant_q   <= '0;
      timeout_q <= 1'b0;
      seg_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (found) begin
            grant_q <= 8'b1 << win;
            gidx_q  <= win;
            seg_q   <= digit(win);
            cnt_q   <= CW'(1);
            ptr_q   <= win - 3'd1;
            state_q <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (rel) begin
            // Timeout only flags a release that neither done nor a dropped request explains.
            timeout_q <= !done && req[gidx_q];
            grant_q   <= '0;
            seg_q     <= '0;
            gap_q     <= GAP_INIT;
            state_q   <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_GAP: begin
          gap_q <= gap_q - 4'd1;
          if (gap_q <= 4'd1) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign none        = ~|grant_q;
  assign timeout     = timeout_q;
  assign segments    = seg_q;

endmodule

// File: tb/tb_rr_display_arbiter.sv
// Scoreboard bench for rr_display_arbiter: a cycle model pushes expected outputs per
// driven cycle, popped and compared one cycle later; scenario-specific checks alongside.
module tb_rr_display_arbiter;

  localparam int unsigned MH = 4;
  localparam int unsigned GC = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic       grant_valid;
  logic       timeout;
  logic [6:0] segments;
  logic       none;

  always #5 clk = ~clk;

  rr_display_arbiter #(.MAX_HOLD(MH), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done), .grant(grant),
    .grant_valid(grant_valid), .timeout(timeout), .segments(segments), .none(none)
  );

  int vectors = 0;
  int errors  = 0;

  logic [17:0] sb[$];
  logic [17:0] expv;
  localparam logic [17:0] RST_OUT = {8'h00, 1'b0, 1'b0, 7'b0000000, 1'b1};

  logic [6:0] SEG [0:7] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                            7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111};

  typedef enum {M_IDLE, M_GRANT, M_GAP} mstate_t;
  mstate_t    m_st;
  int         m_ptr, m_k, m_cnt, m_gap;
  logic [7:0] m_g;
  logic       m_to;

  function automatic logic [17:0] m_out();
    return {m_g, (m_g != 0), m_to, (m_g != 0) ? SEG[m_k] : 7'b0, (m_g == 0)};
  endfunction

  function automatic logic [17:0] dut_out();
    return {grant, grant_valid, timeout, segments, none};
  endfunction

  function automatic int gidx(input logic [7:0] g);
    int r = -1;
    for (int i = 0; i < 8; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_ptr = 7; m_k = 0; m_cnt = 0; m_gap = 0; m_g = '0; m_to = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    bit f = 0;
    int j;
    m_to = 1'b0;
    case (m_st)
      M_IDLE: begin
        for (int i = 0; i < 8; i++) begin
          j = (m_ptr - i + 8) % 8;
          if (!f && r[j]) begin f = 1; m_k = j; end
        end
        if (f) begin
          m_g = 8'(1 << m_k); m_cnt = 1; m_ptr = (m_k + 7) % 8; m_st = M_GRANT;
        end
      end
      M_GRANT: begin
        if (d || !r[m_k] || (MH != 0 && m_cnt == MH)) begin
          m_to  = !d && r[m_k];
          m_g   = '0;
          m_gap = GC;
          m_st  = (GC == 0) ? M_IDLE : M_GAP;
        end else begin
          m_cnt++;
        end
      end
      default: begin
        m_gap--;
        if (m_gap == 0) m_st = M_IDLE;
      end
    endcase
  endtask

  task automatic tick(input logic [7:0] r, input logic d);
    req = r; done = d;
    model_edge(r, d);
    sb.push_back(m_out());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; done = 1'b0;
    model_reset();
    sb.delete();
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'hFF; done = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (dut_out() !== RST_OUT) begin
      errors++; $display("FAIL reset_state got %h want %h", dut_out(), RST_OUT);
    end
    @(posedge clk); #1;
    vectors++;
    if (dut_out() !== RST_OUT) begin
      errors++; $display("FAIL reset_held got %h want %h", dut_out(), RST_OUT);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(8'hFF, 1'b0);
    expv = sb.pop_front(); vectors++;
    if (dut_out() !== expv) begin
      errors++; $display("FAIL reset_first_grant got %h want %h", dut_out(), expv);
    end
    vectors++;
    if (grant !== 8'h80 || segments !== 7'b0000111 || none !== 1'b0) begin
      errors++; $display("FAIL reset_prio7 got grant=%h seg=%b none=%b want 80 0000111 0",
                         grant, segments, none);
    end
  endtask

  task automatic test_alternate();
    int seq[$];
    int want[4] = '{7, 0, 7, 0};
    logic pv = 1'b0;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      tick(8'h81, m_st == M_GRANT);
      expv = sb.pop_front(); vectors++;
      if (dut_out() !== expv) begin
        errors++; $display("FAIL alternate cyc%0d got %h want %h", c, dut_out(), expv);
      end
      if (grant_valid && !pv) seq.push_back(gidx(grant));
      pv = grant_valid;
    end
    vectors++;
    if (seq.size() < 4) begin
      errors++; $display("FAIL alternate_count got %0d want >=4", seq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (seq[i] != want[i]) begin
          errors++; $display("FAIL alternate_order[%0d] got %0d want %0d", i, seq[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_timeout_rr();
    int seq[$];
    int want[10] = '{7, 6, 5, 4, 3, 2, 1, 0, 7, 6};
    int tcnt = 0;
    logic pv = 1'b0;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      tick(8'hFF, 1'b0);
      expv = sb.pop_front(); vectors++;
      if (dut_out() !== expv) begin
        errors++; $display("FAIL timeout_rr cyc%0d got %h want %h", c, dut_out(), expv);
      end
      if (grant_valid && !pv) seq.push_back(gidx(grant));
      if (timeout === 1'b1) tcnt++;
      pv = grant_valid;
    end
    vectors++;
    if (tcnt != 10) begin
      errors++; $display("FAIL timeout_pulses got %0d want 10", tcnt);
    end
    vectors++;
    if (seq.size() != 10) begin
      errors++; $display("FAIL timeout_rr_count got %0d want 10", seq.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        vectors++;
        if (seq[i] != want[i]) begin
          errors++; $display("FAIL timeout_rr_order[%0d] got %0d want %0d", i, seq[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_drop_and_done();
    do_reset();
    tick(8'h08, 1'b0);
    expv = sb.pop_front(); vectors++;
    if (dut_out() !== expv || grant !== 8'h08) begin
      errors++; $display("FAIL drop_grant3 got %h want %h", dut_out(), expv);
    end
    tick(8'h00, 1'b1);
    expv = sb.pop_front(); vectors++;
    if (dut_out() !== expv || dut_out() !== RST_OUT) begin
      errors++; $display("FAIL drop_release got %h want %h", dut_out(), RST_OUT);
    end
    for (int c = 0; c < 3; c++) begin
      tick(8'h00, 1'b0);
      expv = sb.pop_front(); vectors++;
      if (dut_out() !== expv) begin
        errors++; $display("FAIL drop_after cyc%0d got %h want %h", c, dut_out(), expv);
      end
    end
  endtask

  task automatic test_done_at_max();
    int tcnt = 0;
    int rels = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (m_st == M_GRANT && m_cnt == MH) rels++;
      tick(8'h01, m_st == M_GRANT && m_cnt == MH);
      expv = sb.pop_front(); vectors++;
      if (dut_out() !== expv) begin
        errors++; $display("FAIL done_at_max cyc%0d got %h want %h", c, dut_out(), expv);
      end
      if (timeout === 1'b1) tcnt++;
    end
    vectors++;
    if (tcnt != 0 || rels != 1) begin
      errors++; $display("FAIL done_at_max_timeout got %0d pulses (%0d releases) want 0 (1)",
                         tcnt, rels);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      tick(8'h20, 1'b0);
      expv = sb.pop_front(); vectors++;
      if (dut_out() !== expv) begin
        errors++; $display("FAIL midrst_grant cyc%0d got %h want %h", c, dut_out(), expv);
      end
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (dut_out() !== RST_OUT) begin
      errors++; $display("FAIL midrst_async got %h want %h", dut_out(), RST_OUT);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(8'h21, 1'b0);
    expv = sb.pop_front(); vectors++;
    if (dut_out() !== expv || grant !== 8'h20) begin
      errors++; $display("FAIL midrst_regrant got %h want %h", dut_out(), expv);
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick(8'h00, 1'b0);
      expv = sb.pop_front(); vectors++;
      if (dut_out() !== expv) begin
        errors++; $display("FAIL idle cyc%0d got %h want %h", c, dut_out(), expv);
      end
      if (dut_out() !== RST_OUT) bad++;
    end
    vectors++;
    if (bad != 0) begin
      errors++; $display("FAIL idle_quiet got %0d non-idle cycles want 0", bad);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alternate();
    test_timeout_rr();
    test_drop_and_done();
    test_done_at_max();
    test_reset_mid_grant();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
